// File: rtl/uart_msg_checker_pkg.sv
// Shared types and helpers for uart_msg_checker: state encoding, widths, char select.
package uart_msg_checker_pkg;

    localparam int unsigned MAX_MSG_LENGTH = 16;
    localparam int unsigned MSG_W          = 8 * MAX_MSG_LENGTH;
    localparam int unsigned IDX_W          = 4;
    localparam int unsigned COUNT_W        = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        PASS   = 2'd2,
        FAIL   = 2'd3
    } state_t;

    // Character idx of a len-byte string whose first char sits in the MSBs.
    function automatic logic [7:0] char_at(
        input logic [MSG_W-1:0]  s,
        input int unsigned       len,
        input logic [IDX_W-1:0]  idx
    );
        logic [MSG_W-1:0] shifted;
        shifted = s >> (8 * (len - 1 - 32'(idx)));
        return shifted[7:0];
    endfunction

endpackage

// File: rtl/uart_msg_checker_cycle_timeout_counter.sv
// Cycle counter that flags expiry when it reaches MAX-1; MAX == 0 never expires.
module cycle_timeout_counter #(
    parameter int unsigned MAX = 100000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic en,
    output logic expired
);

    localparam int unsigned W     = (MAX < 1) ? 1 : $clog2(MAX + 1);
    localparam logic [W-1:0] LIMIT = W'(MAX - 1);

    logic [W-1:0] count;

    // Count enabled cycles, holding at the limit once reached.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (en && (count != LIMIT)) begin
            count <= count + W'(1);
        end
    end

    assign expired = (MAX != 0) && (count == LIMIT);

endmodule

// File: rtl/uart_msg_checker.sv
// Checks that an expected byte string arrives on a ready/valid byte stream.
// Optional feature: define MSG_CHECK_RESYNC_EN to restart matching on mismatch
// (stream search) instead of failing; failure then comes only from timeout.
module uart_msg_checker
    import uart_msg_checker_pkg::*;
#(
    parameter int unsigned               MSG_LENGTH     = 4,
    parameter logic [8*MSG_LENGTH-1:0]   EXPECTED       = "151>",
    parameter int unsigned               TIMEOUT_CYCLES = 100000
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [7:0]               data_in,
    input  logic                     data_in_valid,
    output logic                     data_in_ready,
    output logic                     busy,
    output logic                     pass,
    output logic                     fail,
    output logic                     timed_out,
    output logic [3:0]               mismatch_idx,
    output logic [15:0]              rx_count,
    output logic [8*MSG_LENGTH-1:0]  captured
);

    localparam int unsigned      CAP_W = 8 * MSG_LENGTH;
    localparam logic [IDX_W-1:0] LAST  = IDX_W'(MSG_LENGTH - 1);

    state_t               state, state_next;
    logic [IDX_W-1:0]     idx, idx_next;
    logic                 pass_next, fail_next, timed_out_next;
    logic [IDX_W-1:0]     mismatch_idx_next;
    logic [COUNT_W-1:0]   rx_count_next;
    logic [CAP_W-1:0]     captured_next;
    logic                 timer_clear;
    logic                 timer_expired;
    logic                 accept;
    logic [7:0]           exp_char;
`ifdef MSG_CHECK_RESYNC_EN
    logic [7:0]           first_char;
`endif

    assign data_in_ready = (state == ACTIVE);
    assign busy          = (state == ACTIVE);
    assign accept        = data_in_valid && data_in_ready;
    assign exp_char      = char_at(MSG_W'(EXPECTED), MSG_LENGTH, idx);
`ifdef MSG_CHECK_RESYNC_EN
    assign first_char    = char_at(MSG_W'(EXPECTED), MSG_LENGTH, IDX_W'(0));
`endif

    cycle_timeout_counter #(
        .MAX(TIMEOUT_CYCLES)
    ) u_timer (
        .clk    (clk),
        .reset  (reset),
        .clear  (timer_clear),
        .en     (busy),
        .expired(timer_expired)
    );

    // State and result registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            idx          <= '0;
            pass         <= 1'b0;
            fail         <= 1'b0;
            timed_out    <= 1'b0;
            mismatch_idx <= '0;
            rx_count     <= '0;
            captured     <= '0;
        end else begin
            state        <= state_next;
            idx          <= idx_next;
            pass         <= pass_next;
            fail         <= fail_next;
            timed_out    <= timed_out_next;
            mismatch_idx <= mismatch_idx_next;
            rx_count     <= rx_count_next;
            captured     <= captured_next;
        end
    end

    // Next-state and result update: arm on start, match bytes, resolve timeout.
    always_comb begin
        state_next        = state;
        idx_next          = idx;
        pass_next         = pass;
        fail_next         = fail;
        timed_out_next    = timed_out;
        mismatch_idx_next = mismatch_idx;
        rx_count_next     = rx_count;
        captured_next     = captured;
        timer_clear       = 1'b0;

        case (state)
            IDLE, PASS, FAIL: begin
                if (start) begin
                    state_next        = ACTIVE;
                    idx_next          = '0;
                    pass_next         = 1'b0;
                    fail_next         = 1'b0;
                    timed_out_next    = 1'b0;
                    mismatch_idx_next = '0;
                    rx_count_next     = '0;
                    captured_next     = '0;
                    timer_clear       = 1'b1;
                end
            end
            ACTIVE: begin
                if (accept) begin
                    captured_next = CAP_W'({captured, data_in});
                    if (rx_count != 16'hFFFF) begin
                        rx_count_next = rx_count + 16'd1;
                    end
                    if (data_in == exp_char) begin
                        if (idx == LAST) begin
                            state_next = PASS;
                            pass_next  = 1'b1;
                        end else begin
                            idx_next = idx + IDX_W'(1);
                        end
                    end else begin
                        mismatch_idx_next = idx;
`ifdef MSG_CHECK_RESYNC_EN
                        idx_next = (data_in == first_char) ? IDX_W'(1) : IDX_W'(0);
`else
                        state_next     = FAIL;
                        fail_next      = 1'b1;
                        timed_out_next = 1'b0;
`endif
                    end
                end
                // A deciding byte in the same cycle beats the timeout.
                if ((state_next == ACTIVE) && timer_expired) begin
                    state_next     = FAIL;
                    fail_next      = 1'b1;
                    timed_out_next = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_uart_msg_checker.sv
// Directed scoreboard bench for uart_msg_checker (MSG_LENGTH=4, "151>", timeout 50).
// Honours MSG_CHECK_RESYNC_EN when defined for the build.
module tb_uart_msg_checker;

    logic        clk;
    logic        reset;
    logic        start;
    logic [7:0]  data_in;
    logic        data_in_valid;
    logic        data_in_ready;
    logic        busy;
    logic        pass;
    logic        fail;
    logic        timed_out;
    logic [3:0]  mismatch_idx;
    logic [15:0] rx_count;
    logic [31:0] captured;

    typedef struct {
        logic        pass;
        logic        fail;
        logic        timed_out;
        logic [3:0]  midx;
        logic [15:0] rx;
        logic [31:0] cap;
    } exp_t;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;

    uart_msg_checker #(
        .MSG_LENGTH    (4),
        .EXPECTED      ("151>"),
        .TIMEOUT_CYCLES(50)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .data_in      (data_in),
        .data_in_valid(data_in_valid),
        .data_in_ready(data_in_ready),
        .busy         (busy),
        .pass         (pass),
        .fail         (fail),
        .timed_out    (timed_out),
        .mismatch_idx (mismatch_idx),
        .rx_count     (rx_count),
        .captured     (captured)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // All drive tasks are entered and left on a falling edge.
    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        data_in       = b;
        data_in_valid = 1'b1;
        @(negedge clk);
        data_in_valid = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic send_str(input string s, input int gap);
        for (int i = 0; i < s.len(); i++) send_byte(s[i], gap);
    endtask

    task automatic push(input logic p, input logic f, input logic t,
                        input logic [3:0] m, input logic [15:0] r, input logic [31:0] c);
        exp_t e;
        e.pass = p; e.fail = f; e.timed_out = t; e.midx = m; e.rx = r; e.cap = c;
        sb.push_back(e);
    endtask

    task automatic pop_check(input string tag);
        exp_t e;
        int   n = 0;
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_done"}, 32'(busy), 32'd0);
        if (sb.size() == 0) begin
            miscompares++;
            $error("FAIL %s_sb: observed empty expected entry", tag);
        end else begin
            e = sb.pop_front();
            check({tag, "_pass"}, 32'(pass), 32'(e.pass));
            check({tag, "_fail"}, 32'(fail), 32'(e.fail));
            check({tag, "_timed_out"}, 32'(timed_out), 32'(e.timed_out));
            check({tag, "_midx"}, 32'(mismatch_idx), 32'(e.midx));
            check({tag, "_rx"}, 32'(rx_count), 32'(e.rx));
            check({tag, "_cap"}, captured, e.cap);
            check({tag, "_ready"}, 32'(data_in_ready), 32'd0);
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; data_in = 8'h00; data_in_valid = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Reset state
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_pass", 32'(pass), 32'd0);
        check("rst_fail", 32'(fail), 32'd0);
        check("rst_to", 32'(timed_out), 32'd0);
        check("rst_ready", 32'(data_in_ready), 32'd0);
        check("rst_rx", 32'(rx_count), 32'd0);
        check("rst_cap", captured, 32'd0);

        // Valid held high while idle is never accepted
        data_in = 8'h31; data_in_valid = 1'b1;
        repeat (5) @(negedge clk);
        data_in_valid = 1'b0;
        check("idle_rx", 32'(rx_count), 32'd0);
        check("idle_cap", captured, 32'd0);

        // Full match with 10-cycle gaps
        pulse_start();
        check("t1_busy", 32'(busy), 32'd1);
        push(1'b1, 1'b0, 1'b0, 4'd0, 16'd4, 32'h3135313E);
        send_str("151>", 10);
        pop_check("t1");

        // Mismatch on third byte; restart from PASS clears results
        pulse_start();
        check("t2_clr_pass", 32'(pass), 32'd0);
        check("t2_clr_rx", 32'(rx_count), 32'd0);
        check("t2_clr_cap", captured, 32'd0);
`ifdef MSG_CHECK_RESYNC_EN
        push(1'b0, 1'b1, 1'b1, 4'd0, 16'd4, 32'h3135783E);
`else
        push(1'b0, 1'b1, 1'b0, 4'd2, 16'd3, 32'h00313578);
`endif
        send_str("15x", 0);
`ifdef MSG_CHECK_RESYNC_EN
        check("t2_still_busy", 32'(busy), 32'd1);
`else
        check("t2_fail_now", 32'(fail), 32'd1);
        check("t2_ready_low", 32'(data_in_ready), 32'd0);
`endif
        send_str(">", 0);
        pop_check("t2");

        // Timeout exactly 50 cycles after start
        pulse_start();
        check("t3_clr_fail", 32'(fail), 32'd0);
        check("t3_clr_to", 32'(timed_out), 32'd0);
        push(1'b0, 1'b1, 1'b1, 4'd0, 16'd0, 32'd0);
        repeat (49) @(negedge clk);
        check("t3_fail_49", 32'(fail), 32'd0);
        check("t3_busy_49", 32'(busy), 32'd1);
        @(negedge clk);
        check("t3_fail_50", 32'(fail), 32'd1);
        check("t3_to_50", 32'(timed_out), 32'd1);
        pop_check("t3");

        // Leading garbage and a repeated first char
        pulse_start();
`ifdef MSG_CHECK_RESYNC_EN
        push(1'b1, 1'b0, 1'b0, 4'd1, 16'd6, 32'h3135313E);
`else
        push(1'b0, 1'b1, 1'b0, 4'd0, 16'd1, 32'h00000078);
`endif
        send_str("x1151>", 0);
        pop_check("t4");

        // Reset mid-message, then start ignored while active
        pulse_start();
        send_str("15", 0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("t5_rst_busy", 32'(busy), 32'd0);
        check("t5_rst_rx", 32'(rx_count), 32'd0);
        check("t5_rst_cap", captured, 32'd0);
        check("t5_rst_ready", 32'(data_in_ready), 32'd0);
        pulse_start();
        push(1'b1, 1'b0, 1'b0, 4'd0, 16'd4, 32'h3135313E);
        send_str("1", 0);
        pulse_start();
        send_str("51>", 0);
        pop_check("t5");

        // Final byte accepted in the timeout cycle: byte wins
        pulse_start();
        push(1'b1, 1'b0, 1'b0, 4'd0, 16'd4, 32'h3135313E);
        send_str("151", 0);
        repeat (46) @(negedge clk);
        send_str(">", 0);
        pop_check("t6");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
